// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder for the MIPS32 core: arbitrates fetch and data
// req/ack ports onto one array with a fixed, programmable number of wait states.
module mips32_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [2:0]        cnt;
    logic              sel_dm;
    logic              lat_we;
    logic              last_dm;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              any_req;
    logic              grant_dm;
    logic [ADDR_W-1:0] acc_addr;
    logic              enter_resp;
    logic              resp_dm;
    logic              resp_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    // Under contention the port that did not win last time gets the grant.
    assign any_req  = if_req | dm_req;
    assign grant_dm = dm_req & ~(if_req & last_dm);
    assign acc_addr = grant_dm ? dm_addr : if_addr;

    // With zero wait states the response is loaded straight from the accept cycle.
    always_comb begin
        enter_resp = 1'b0;
        resp_dm    = sel_dm;
        resp_we    = lat_we;
        rd_addr    = lat_addr;
        if (state == IDLE) begin
            enter_resp = any_req && (WAIT_STATES == 0);
            resp_dm    = grant_dm;
            resp_we    = grant_dm & dm_we;
            rd_addr    = acc_addr;
        end else if (state == WAIT) begin
            enter_resp = (cnt == 3'd0);
        end
    end

    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            sel_dm    <= 1'b0;
            lat_we    <= 1'b0;
            last_dm   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_dm    <= grant_dm;
                        last_dm   <= grant_dm;
                        lat_we    <= grant_dm & dm_we;
                        lat_addr  <= acc_addr;
                        lat_wdata <= dm_wdata;
                        busy      <= 1'b1;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) state <= RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                if_ack <= ~resp_dm;
                dm_ack <= resp_dm;
                if (!resp_dm)     if_rdata <= rd_word;
                else if (!resp_we) dm_rdata <= rd_word;
            end
        end
    end

    // Stores commit on the edge that ends RESP; a reset on that edge cancels them.
    always_ff @(posedge clk1) begin
        if (!rst && state == RESP && lat_we) mem[lat_addr] <= lat_wdata;
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: one instance per WAIT_STATES value 0..7, each
// checked every cycle against a timestamp-based transaction model, plus directed pins.
module tb_mips32_mem_responder;

    localparam int N    = 8;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int POOL = 19;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b1;
    logic          if_req   [N];
    logic [AW-1:0] if_addr  [N];
    logic          if_ack   [N];
    logic [DW-1:0] if_rdata [N];
    logic          dm_req   [N];
    logic          dm_we    [N];
    logic [AW-1:0] dm_addr  [N];
    logic [DW-1:0] dm_wdata [N];
    logic          dm_ack   [N];
    logic [DW-1:0] dm_rdata [N];
    logic          busy     [N];

    always #5 clk1 = ~clk1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mips32_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(g)) dut (
            .clk1(clk1), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
            .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]), .busy(busy[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    bit model_ready = 0;

    logic [DW-1:0] mmem [N][1024];
    bit            m_active [N];
    int            m_acc    [N];
    bit            m_dm     [N];
    bit            m_we     [N];
    bit            m_last_dm[N];
    logic [AW-1:0] m_addr   [N];
    logic [DW-1:0] m_wdata  [N];
    bit            e_if_ack [N];
    bit            e_dm_ack [N];
    bit            e_busy   [N];
    logic [DW-1:0] e_if_rdata [N];
    logic [DW-1:0] e_dm_rdata [N];

    task automatic check_output(input string name, input int g, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s inst%0d got %h expected %h (edge %0d)", name, g, act, exp, edge_n);
        end
    endtask

    function automatic logic [AW-1:0] pool_addr(input int i);
        if (i < 16) return AW'(i);
        if (i == 16) return AW'(198);
        if (i == 17) return AW'(200);
        return '1;
    endfunction

    // Transaction model: an access accepted at edge A acks after edge A+ws, frees at A+ws+1.
    always @(posedge clk1) begin
        edge_n++;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                m_active[g]   = 0;
                m_last_dm[g]  = 0;
                e_if_rdata[g] = '0;
                e_dm_rdata[g] = '0;
            end else if (m_active[g] && edge_n == m_acc[g] + g + 1) begin
                if (m_dm[g] && m_we[g]) mmem[g][m_addr[g]] = m_wdata[g];
                m_active[g] = 0;
            end else if (!m_active[g] && (if_req[g] || dm_req[g])) begin
                m_active[g]  = 1;
                m_acc[g]     = edge_n;
                m_dm[g]      = dm_req[g] && !(if_req[g] && m_last_dm[g]);
                m_last_dm[g] = m_dm[g];
                m_we[g]      = m_dm[g] && dm_we[g];
                m_addr[g]    = m_dm[g] ? dm_addr[g] : if_addr[g];
                m_wdata[g]   = dm_wdata[g];
            end
            e_busy[g]   = m_active[g];
            e_if_ack[g] = m_active[g] && edge_n == m_acc[g] + g && !m_dm[g];
            e_dm_ack[g] = m_active[g] && edge_n == m_acc[g] + g && m_dm[g];
            if (e_if_ack[g]) e_if_rdata[g] = mmem[g][m_addr[g]];
            if (e_dm_ack[g] && !m_we[g]) e_dm_rdata[g] = mmem[g][m_addr[g]];
        end
        model_ready = 1;
    end

    always @(negedge clk1) begin
        if (model_ready) begin
            for (int g = 0; g < N; g++) begin
                check_output("if_ack",   g, 32'(if_ack[g]), 32'(e_if_ack[g]));
                check_output("dm_ack",   g, 32'(dm_ack[g]), 32'(e_dm_ack[g]));
                check_output("busy",     g, 32'(busy[g]),   32'(e_busy[g]));
                check_output("if_rdata", g, if_rdata[g], e_if_rdata[g]);
                check_output("dm_rdata", g, dm_rdata[g], e_dm_rdata[g]);
            end
        end
    end

    // One handshake on instance g, started at a negedge; ends at the negedge of the following idle cycle.
    task automatic access(input int g, input bit dm, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit drop_early,
                          output logic [DW-1:0] rdata, output int lat, output int busy_cycles);
        if (dm) begin
            dm_req[g] = 1; dm_we[g] = we; dm_addr[g] = addr; dm_wdata[g] = wdata;
        end else begin
            if_req[g] = 1; if_addr[g] = addr;
        end
        lat = 0; busy_cycles = 0; rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk1);
            if (busy[g]) busy_cycles++;
            if (drop_early && c == 1) begin
                dm_req[g] = 0; if_req[g] = 0;
                dm_addr[g] = ~addr; if_addr[g] = ~addr; dm_wdata[g] = ~wdata; dm_we[g] = ~we;
            end
            if (dm ? dm_ack[g] : if_ack[g]) begin
                lat   = c;
                rdata = dm ? dm_rdata[g] : if_rdata[g];
                break;
            end
        end
        dm_req[g] = 0; if_req[g] = 0;
        if (lat == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL timeout inst%0d got no ack expected ack within 40 cycles", g);
        end
        @(negedge clk1);
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk1);
            rst = ($urandom_range(599) == 0);
            for (int g = 0; g < N; g++) begin
                if (if_req[g] && if_ack[g]) if_req[g] = 0;
                else if (if_req[g]) begin
                    if ($urandom_range(15) == 0) if_req[g] = 0;
                    else if ($urandom_range(7) == 0) if_addr[g] = pool_addr($urandom_range(POOL - 1));
                end else if ($urandom_range(2) == 0) begin
                    if_req[g] = 1; if_addr[g] = pool_addr($urandom_range(POOL - 1));
                end
                if (dm_req[g] && dm_ack[g]) dm_req[g] = 0;
                else if (dm_req[g]) begin
                    if ($urandom_range(15) == 0) dm_req[g] = 0;
                    else if ($urandom_range(7) == 0) begin
                        dm_we[g] = 1'($urandom_range(1)); dm_wdata[g] = $urandom;
                    end
                end else if ($urandom_range(2) == 0) begin
                    dm_req[g]   = 1;
                    dm_we[g]    = 1'($urandom_range(1));
                    dm_addr[g]  = pool_addr($urandom_range(POOL - 1));
                    dm_wdata[g] = $urandom;
                end
            end
        end
        rst = 0;
        for (int g = 0; g < N; g++) begin dm_req[g] = 0; if_req[g] = 0; end
        repeat (12) @(negedge clk1);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] wd;
        int lat, bcy, nack;
        int ack_cyc [N][4];
        bit ack_dm  [N][4];
        int nacks   [N];
        for (int g = 0; g < N; g++) begin
            if_req[g] = 0; dm_req[g] = 0; dm_we[g] = 0;
            if_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0;
        end
        rst = 1;
        repeat (3) @(negedge clk1);
        check_output("reset busy",     1, 32'(busy[1]),   0);
        check_output("reset if_ack",   1, 32'(if_ack[1]), 0);
        check_output("reset if_rdata", 1, if_rdata[1],    0);
        check_output("reset dm_rdata", 1, dm_rdata[1],    0);
        rst = 0;
        @(negedge clk1);

        for (int g = 0; g < N; g++)
            for (int i = 0; i < POOL; i++)
                access(g, 1, 1, pool_addr(i), (i == 5) ? 32'h280a00c8 : 32'h0, 0, rd, lat, bcy);

        // Fetch of a preloaded word with one wait state.
        access(1, 0, 0, 10'd5, '0, 0, rd, lat, bcy);
        check_output("T1 latency", 1, lat, 2);
        check_output("T1 if_rdata", 1, rd, 32'h280a00c8);

        access(1, 1, 1, 10'd200, 32'd7, 0, rd, lat, bcy);
        access(1, 1, 0, 10'd200, '0, 0, rd, lat, bcy);
        check_output("T2 load after store", 1, rd, 32'd7);
        check_output("T2 model mem", 1, mmem[1][200], 32'd7);

        access(0, 0, 0, 10'd0, '0, 0, rd, lat, bcy);
        check_output("T4 latency", 0, lat, 1);
        check_output("T4 busy cycles", 0, bcy, 1);
        check_output("T4 if_rdata", 0, rd, 0);

        // Store whose request vanishes right after accept, swept over every wait-state count.
        for (int g = 0; g < N; g++) begin
            wd = $urandom;
            access(g, 1, 1, 10'd10, wd, 1, rd, lat, bcy);
            check_output("T6 latency", g, lat, g + 1);
            check_output("T6 busy cycles", g, bcy, g + 1);
            access(g, 1, 0, 10'd10, '0, 0, rd, lat, bcy);
            check_output("T6 committed data", g, rd, wd);
        end

        dm_req[1] = 1; dm_we[1] = 1; dm_addr[1] = 10'd198; dm_wdata[1] = 32'd9;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk1);
            if (dm_ack[1]) begin lat = c; break; end
        end
        check_output("T5 ack cycle", 1, lat, 2);
        rst = 1; dm_req[1] = 0;
        @(negedge clk1);
        rst = 0;
        check_output("T5 busy", 1, 32'(busy[1]), 0);
        check_output("T5 dm_ack", 1, 32'(dm_ack[1]), 0);
        check_output("T5 dm_rdata", 1, dm_rdata[1], 0);
        check_output("T5 if_rdata", 1, if_rdata[1], 0);
        @(negedge clk1);
        access(1, 1, 0, 10'd198, '0, 0, rd, lat, bcy);
        check_output("T5 mem unchanged", 1, rd, 0);

        dm_req[3] = 1; dm_we[3] = 1; dm_addr[3] = 10'd198; dm_wdata[3] = 32'd9;
        repeat (3) @(negedge clk1);
        rst = 1; dm_req[3] = 0;
        nack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk1);
            rst = 0;
            if (dm_ack[3]) nack++;
        end
        check_output("T5 aborted acks", 3, nack, 0);
        access(3, 1, 0, 10'd198, '0, 0, rd, lat, bcy);
        check_output("T5 aborted store", 3, rd, 0);

        // Both ports requesting continuously out of reset.
        rst = 1;
        for (int g = 0; g < N; g++) begin
            if_req[g] = 1; if_addr[g] = 10'd3;
            dm_req[g] = 1; dm_we[g] = 0; dm_addr[g] = 10'd4;
            nacks[g] = 0;
        end
        repeat (2) @(negedge clk1);
        rst = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk1);
            for (int g = 0; g < N; g++) begin
                if (nacks[g] < 4 && (if_ack[g] || dm_ack[g])) begin
                    ack_cyc[g][nacks[g]] = c;
                    ack_dm[g][nacks[g]]  = dm_ack[g];
                    nacks[g]++;
                end
            end
        end
        for (int g = 0; g < N; g++) begin
            if_req[g] = 0; dm_req[g] = 0;
            check_output("T3 ack count", g, nacks[g], 4);
            for (int k = 0; k < 4; k++) begin
                check_output("T3 grant order", g, 32'(ack_dm[g][k]), 32'(k % 2 == 0));
                if (k > 0) check_output("T3 ack spacing", g, ack_cyc[g][k] - ack_cyc[g][k-1], g + 2);
            end
        end
        repeat (12) @(negedge clk1);

        apply_stimulus(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got no finish expected finish before 200000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
